// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine for the 320x240 RGB565 frame buffer.
// Clips each command to the screen and emits one row-major frame-buffer write per clock.
module fb_rect_writer #(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int ADDR_W      = 17,
  parameter bit SYNC_VBLANK = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [15:0]       cmd_color,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_FILL, S_DONE} state_t;

  localparam logic [9:0] H_RES10 = 10'(H_RES);
  localparam logic [9:0] V_RES10 = 10'(V_RES);

  state_t state, state_nx;

  logic              accept, start_fill;
  logic [9:0]        x_ext, y_ext, w_ext, h_ext;
  logic [9:0]        rem_x, rem_y, clip_w, clip_h;
  logic              cmd_empty;
  logic [ADDR_W-1:0] y_base;

  logic [8:0]        x_q;
  logic [ADDR_W-1:0] base_q;
  logic [9:0]        ew_q, eh_q;
  logic [15:0]       color_q;

  logic [9:0]        col_cnt, row_cnt;
  logic [8:0]        cur_col;
  logic [ADDR_W-1:0] cur_base;
  logic [15:0]       data_q;
  logic              last_col, last_row;

  // Clip at 10 bits so H_RES-x and V_RES-y cannot wrap for on-screen origins.
  assign x_ext     = {1'b0, cmd_x};
  assign y_ext     = {2'b00, cmd_y};
  assign w_ext     = {1'b0, cmd_w};
  assign h_ext     = {2'b00, cmd_h};
  assign rem_x     = H_RES10 - x_ext;
  assign rem_y     = V_RES10 - y_ext;
  assign clip_w    = (w_ext < rem_x) ? w_ext : rem_x;
  assign clip_h    = (h_ext < rem_y) ? h_ext : rem_y;
  assign cmd_empty = (x_ext >= H_RES10) || (y_ext >= V_RES10) ||
                     (clip_w == 10'd0) || (clip_h == 10'd0);
  assign y_base    = ADDR_W'(cmd_y) * ADDR_W'(H_RES);

  assign last_col  = (col_cnt == ew_q - 10'd1);
  assign last_row  = (row_cnt == eh_q - 10'd1);

  assign wr_addr   = cur_base + ADDR_W'(cur_col);
  assign wr_data   = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    start_fill = 1'b0;
    cmd_ready  = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = ~rst;
        accept    = cmd_valid & ~rst;
        if (accept) begin
          if (cmd_empty)        state_nx = S_DONE;
          else if (SYNC_VBLANK) state_nx = S_WAIT_VB;
          else begin
            state_nx   = S_FILL;
            start_fill = 1'b1;
          end
        end
      end
      S_WAIT_VB: begin
        busy = 1'b1;
        if (vblank) begin
          state_nx   = S_FILL;
          start_fill = 1'b1;
        end
      end
      S_FILL: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (last_col && last_row) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pointer registers only move while writing, so the address/data hold between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      base_q   <= '0;
      ew_q     <= '0;
      eh_q     <= '0;
      color_q  <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      cur_col  <= '0;
      cur_base <= '0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        x_q     <= cmd_x;
        base_q  <= y_base;
        ew_q    <= clip_w;
        eh_q    <= clip_h;
        color_q <= cmd_color;
      end
      if (start_fill) begin
        col_cnt <= '0;
        row_cnt <= '0;
        if (state == S_IDLE) begin
          cur_col  <= cmd_x;
          cur_base <= y_base;
          data_q   <= cmd_color;
        end else begin
          cur_col  <= x_q;
          cur_base <= base_q;
          data_q   <= color_q;
        end
      end else if (state == S_FILL && !last_col) begin
        col_cnt <= col_cnt + 10'd1;
        cur_col <= cur_col + 9'd1;
      end else if (state == S_FILL && !last_row) begin
        col_cnt  <= '0;
        row_cnt  <= row_cnt + 10'd1;
        cur_col  <= x_q;
        cur_base <= cur_base + ADDR_W'(H_RES);
      end
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: a per-cycle reference trace is built from each accepted command
// (clip, then y*H_RES+x for every pixel) and compared against the DUT on every falling edge.
module tb_fb_rect_writer;

  localparam int H = 320;
  localparam int V = 240;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;

  logic        cmd_valid = 1'b0;
  logic [8:0]  cmd_x = '0, cmd_w = '0;
  logic [7:0]  cmd_y = '0, cmd_h = '0;
  logic [15:0] cmd_color = '0;
  logic        cmd_ready, wr_en, busy, done;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;

  logic        cmd_valid_s = 1'b0;
  logic [8:0]  cmd_x_s = '0, cmd_w_s = '0;
  logic [7:0]  cmd_y_s = '0, cmd_h_s = '0;
  logic [15:0] cmd_color_s = '0;
  logic        cmd_ready_s, wr_en_s, busy_s, done_s;
  logic [16:0] wr_addr_s;
  logic [15:0] wr_data_s;

  fb_rect_writer #(.SYNC_VBLANK(1'b0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .vblank(vblank), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  fb_rect_writer #(.SYNC_VBLANK(1'b1)) dut_s (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
    .cmd_x(cmd_x_s), .cmd_y(cmd_y_s), .cmd_w(cmd_w_s), .cmd_h(cmd_h_s), .cmd_color(cmd_color_s),
    .vblank(vblank), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   seen[$];
  int   exp_list[$];
  int   total = 0;
  int   bad = 0;
  bit   model_ready = 1'b0;
  int   last_addr = 0;
  int   last_data = 0;
  int   seen_count = 0;
  int   seen_last = -1;

  function automatic void checkOutput(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endfunction

  // Reference: expected per-cycle trace of one command, starting the cycle after accept.
  function automatic void modelCommand(int x, int y, int w, int h, int c);
    int   ew, eh;
    exp_t e;
    ew = 0;
    eh = 0;
    if (x < H && y < V) begin
      ew = (w < H - x) ? w : H - x;
      eh = (h < V - y) ? h : V - y;
    end
    if (ew > 0 && eh > 0) begin
      for (int r = 0; r < eh; r++) begin
        for (int cc = 0; cc < ew; cc++) begin
          e.en = 1'b1; e.addr = (y + r) * H + x + cc; e.data = c; e.done = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
    e.en = 1'b0; e.addr = 0; e.data = 0; e.done = 1'b1;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checkOutput("rst_wr_en", int'(wr_en), 0);
      checkOutput("rst_wr_addr", int'(wr_addr), 0);
      checkOutput("rst_wr_data", int'(wr_data), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_cmd_ready", int'(cmd_ready), 0);
      model_ready = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("wr_en", int'(wr_en), int'(e.en));
      if (e.en) begin
        checkOutput("wr_addr", int'(wr_addr), e.addr);
        checkOutput("wr_data", int'(wr_data), e.data);
        last_addr = e.addr;
        last_data = e.data;
        seen.push_back(int'(wr_addr));
        seen_count++;
        seen_last = int'(wr_addr);
      end else begin
        checkOutput("hold_addr", int'(wr_addr), last_addr);
        checkOutput("hold_data", int'(wr_data), last_data);
      end
      checkOutput("done", int'(done), int'(e.done));
      checkOutput("busy", int'(busy), 1);
      checkOutput("cmd_ready_busy", int'(cmd_ready), 0);
      model_ready = 1'b0;
    end else begin
      checkOutput("idle_wr_en", int'(wr_en), 0);
      checkOutput("idle_done", int'(done), 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_cmd_ready", int'(cmd_ready), 1);
      checkOutput("idle_addr", int'(wr_addr), last_addr);
      checkOutput("idle_data", int'(wr_data), last_data);
      model_ready = 1'b1;
    end
  end

  task automatic applyStimulus(input int x, input int y, input int w, input int h, input int c);
    int n;
    @(negedge clk);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 16'(c);
    cmd_valid = 1'b1;
    n = 0;
    @(posedge clk);
    while (!model_ready && n < 90000) begin
      @(posedge clk);
      n++;
    end
    if (model_ready) modelCommand(x, y, w, h, c);
    else begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: command (%0d,%0d,%0d,%0d) never accepted", x, y, w, h);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && model_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(exp_q.size() == 0 && model_ready)) begin
      total++; bad++;
      $display("[TB] FAIL idle_timeout: %0d records left after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic checkSeen(input string name);
    checkOutput({name, "_count"}, seen.size(), exp_list.size());
    for (int i = 0; i < exp_list.size(); i++)
      checkOutput({name, "_addr"}, (i < seen.size()) ? seen[i] : -1, exp_list[i]);
  endtask

  initial begin
    #23 rst = 1'b0;

    // Vblank-synchronised instance: hold for 50 cycles, then write once vblank is seen.
    @(negedge clk);
    checkOutput("s_ready", int'(cmd_ready_s), 1);
    cmd_x_s = 9'd4; cmd_y_s = 8'd2; cmd_w_s = 9'd3; cmd_h_s = 8'd2; cmd_color_s = 16'h07E0;
    cmd_valid_s = 1'b1;
    @(posedge clk);
    #1 cmd_valid_s = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("s_wait_wr_en", int'(wr_en_s), 0);
      checkOutput("s_wait_busy", int'(busy_s), 1);
      checkOutput("s_wait_addr", int'(wr_addr_s), 0);
    end
    vblank = 1'b1;
    exp_list = {644, 645, 646, 964, 965, 966};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("s_fill_wr_en", int'(wr_en_s), 1);
      checkOutput("s_fill_addr", int'(wr_addr_s), exp_list[i]);
      checkOutput("s_fill_data", int'(wr_data_s), 16'h07E0);
      vblank = 1'b0;
    end
    @(negedge clk);
    checkOutput("s_done", int'(done_s), 1);
    checkOutput("s_done_wr_en", int'(wr_en_s), 0);
    @(negedge clk);
    checkOutput("s_idle_busy", int'(busy_s), 0);

    seen.delete();
    applyStimulus(10, 5, 2, 2, 16'hF800);
    waitIdle(100);
    exp_list = {1610, 1611, 1930, 1931};
    checkSeen("basic");

    seen.delete();
    applyStimulus(318, 239, 10, 5, 16'h1234);
    waitIdle(100);
    exp_list = {76798, 76799};
    checkSeen("clip_corner");

    seen.delete();
    applyStimulus(320, 0, 4, 4, 16'h5555);
    applyStimulus(0, 0, 0, 7, 16'hAAAA);
    waitIdle(100);
    exp_list = {};
    checkSeen("empty");

    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 0)
        applyStimulus($urandom_range(300, 330), $urandom_range(228, 245),
                      $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 65535));
      else
        applyStimulus($urandom_range(0, 340), $urandom_range(0, 250),
                      $urandom_range(0, 24), $urandom_range(0, 12), $urandom_range(0, 65535));
    end
    waitIdle(2000);

    applyStimulus(0, 10, 50, 20, 16'hABCD);
    repeat (37) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_wr_en", int'(wr_en), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    #1 rst = 1'b0;
    exp_q.delete();
    last_addr = 0;
    last_data = 0;
    model_ready = 1'b1;
    seen.delete();
    applyStimulus(5, 7, 3, 2, 16'h0F0F);
    waitIdle(100);
    exp_list = {2245, 2246, 2247, 2565, 2566, 2567};
    checkSeen("after_rst");

    seen.delete();
    seen_count = 0;
    seen_last = -1;
    applyStimulus(0, 0, 320, 240, 16'h001F);
    waitIdle(80000);
    checkOutput("clear_count", seen_count, 76800);
    checkOutput("clear_last", seen_last, 76799);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
